crank_ign_stim_gen: RTL and testbench

CRANK_IGN_STIM_GEN -- requirements
Module: crank_ign_stim_gen

---
 rtl/crank_ign_stim_gen.sv | 175 +++++++++++++++++
 tb/tb_crank_ign_stim_gen.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/crank_ign_stim_gen.sv
// Crankshaft / ignition stimulus generator.
// Produces a periodic reference trigger pulse, an ignition (dwell) square wave
// and a one-hot cylinder index. The period is optionally swept from
// period_start toward period_end to emulate an RPM ramp.
// Optional feature macro: STIM_RAMP_EN (RPM ramp and HOLD state). Without it
// the period stays at max(period_start, 2) and sweep_done is tied low.
module crank_ign_stim_gen #(
    parameter int CNT_W  = 24,
    parameter int N_CYL  = 4,
    parameter int STEP_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [CNT_W-1:0]  period_start,
    input  logic [CNT_W-1:0]  period_end,
    input  logic [STEP_W-1:0] period_step,
    input  logic [7:0]        ramp_div,
    input  logic [CNT_W-1:0]  trig_pos,
    input  logic [CNT_W-1:0]  trig_len,
    input  logic [CNT_W-1:0]  ign_pos,
    output logic              trigger,
    output logic              ign,
    output logic [N_CYL-1:0]  cyl,
    output logic [CNT_W-1:0]  period_cur,
    output logic              sweep_done
);

`ifdef STIM_RAMP_EN
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1} state_t;
`endif

    state_t            state, state_n;
    logic [CNT_W-1:0]  counter, counter_n;
    logic [CNT_W-1:0]  period_n;
    logic [N_CYL-1:0]  cyl_n, cyl_rot;
    logic              trigger_n, ign_n;
    logic [CNT_W:0]    cnt_x, cnt_p1, tp_x, tend_x;
    logic              in_trig, in_ign, wrap;

    // A period shorter than 2 clocks would make the counter degenerate.
    function automatic logic [CNT_W-1:0] clamp_min2(input logic [CNT_W-1:0] v);
        return (v < CNT_W'(2)) ? CNT_W'(2) : v;
    endfunction

    // Window compares are done one bit wider so trig_pos+trig_len cannot wrap.
    assign cnt_x   = {1'b0, counter};
    assign cnt_p1  = cnt_x + (CNT_W+1)'(1);
    assign tp_x    = {1'b0, trig_pos};
    assign tend_x  = tp_x + {1'b0, trig_len};
    assign in_trig = (cnt_x >= tp_x) && (cnt_x < tend_x);
    assign in_ign  = (counter >= ign_pos);
    assign wrap    = (cnt_p1 >= {1'b0, period_cur});
    assign cyl_rot = (cyl << 1) | (cyl >> (N_CYL-1));

`ifdef STIM_RAMP_EN
    logic [7:0]     ramp_cnt, ramp_cnt_n;
    logic           sweep_r, sweep_n;
    logic [CNT_W:0] pc_x, pe_x, step_x, dist, pc_dn, pc_up;

    assign pc_x       = {1'b0, period_cur};
    assign pe_x       = {1'b0, period_end};
    assign step_x     = (CNT_W+1)'(period_step);
    assign dist       = (pc_x > pe_x) ? (pc_x - pe_x) : (pe_x - pc_x);
    assign pc_dn      = pc_x - step_x;
    assign pc_up      = pc_x + step_x;
    assign sweep_done = sweep_r;
`else
    logic unused_ramp;
    assign unused_ramp = ^{period_end, period_step, ramp_div};
    assign sweep_done  = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state, counter, cylinder rotation, ramp update and output decode
    always_comb begin
        state_n   = state;
        counter_n = counter;
        period_n  = period_cur;
        cyl_n     = cyl;
        trigger_n = 1'b0;
        ign_n     = 1'b0;
`ifdef STIM_RAMP_EN
        ramp_cnt_n = ramp_cnt;
        sweep_n    = sweep_r;
`endif
        if (state == IDLE) begin
            counter_n = '0;
            cyl_n     = N_CYL'(1);
`ifdef STIM_RAMP_EN
            ramp_cnt_n = '0;
            sweep_n    = 1'b0;
`endif
            if (en) begin
                state_n  = RUN;
                period_n = clamp_min2(period_start);
`ifdef STIM_RAMP_EN
                if (period_start == period_end) begin
                    state_n = HOLD;
                    sweep_n = 1'b1;
                end
`endif
            end
        end else if (!en) begin
            state_n   = IDLE;
            counter_n = '0;
            cyl_n     = N_CYL'(1);
`ifdef STIM_RAMP_EN
            ramp_cnt_n = '0;
            sweep_n    = 1'b0;
`endif
        end else begin
            trigger_n = in_trig;
            ign_n     = in_ign;
            if (wrap) begin
                counter_n = '0;
                cyl_n     = cyl_rot;
`ifdef STIM_RAMP_EN
                // HOLD keeps the final period; only RUN advances the ramp.
                if (state == RUN) begin
                    if (ramp_cnt >= ramp_div) begin
                        ramp_cnt_n = '0;
                        if (dist <= step_x) begin
                            period_n = clamp_min2(period_end);
                            sweep_n  = 1'b1;
                            state_n  = HOLD;
                        end else if (pc_x > pe_x) begin
                            period_n = clamp_min2(pc_dn[CNT_W-1:0]);
                        end else begin
                            period_n = pc_up[CNT_W-1:0];
                        end
                    end else begin
                        ramp_cnt_n = ramp_cnt + 8'd1;
                    end
                end
`endif
            end else begin
                counter_n = counter + CNT_W'(1);
            end
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter    <= '0;
            period_cur <= '0;
            cyl        <= N_CYL'(1);
            trigger    <= 1'b0;
            ign        <= 1'b0;
`ifdef STIM_RAMP_EN
            ramp_cnt   <= '0;
            sweep_r    <= 1'b0;
`endif
        end else begin
            counter    <= counter_n;
            period_cur <= period_n;
            cyl        <= cyl_n;
            trigger    <= trigger_n;
            ign        <= ign_n;
`ifdef STIM_RAMP_EN
            ramp_cnt   <= ramp_cnt_n;
            sweep_r    <= sweep_n;
`endif
        end
    end

endmodule

// File: tb/tb_crank_ign_stim_gen.sv
// Scoreboard bench for crank_ign_stim_gen: a behavioural model predicts the
// outputs after each clock edge, a monitor compares them on the falling edge.
module tb_crank_ign_stim_gen;
    localparam int CNT_W  = 24;
    localparam int N_CYL  = 4;
    localparam int STEP_W = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b0;
    logic [CNT_W-1:0]  period_start = '0, period_end = '0;
    logic [STEP_W-1:0] period_step = '0;
    logic [7:0]        ramp_div = '0;
    logic [CNT_W-1:0]  trig_pos = '0, trig_len = '0, ign_pos = '0;
    logic              trigger, ign, sweep_done;
    logic [N_CYL-1:0]  cyl;
    logic [CNT_W-1:0]  period_cur;

    crank_ign_stim_gen #(.CNT_W(CNT_W), .N_CYL(N_CYL), .STEP_W(STEP_W)) dut (
        .clk(clk), .rst(rst), .en(en),
        .period_start(period_start), .period_end(period_end),
        .period_step(period_step), .ramp_div(ramp_div),
        .trig_pos(trig_pos), .trig_len(trig_len), .ign_pos(ign_pos),
        .trigger(trigger), .ign(ign), .cyl(cyl),
        .period_cur(period_cur), .sweep_done(sweep_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             trig;
        logic             ign;
        logic [N_CYL-1:0] cyl;
        logic [CNT_W-1:0] pc;
        logic             sd;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Tracks running/holding, position within the period, number of periods
    // since the run started and the period currently in force.
    bit     m_run = 0, m_hold = 0, m_trig = 0, m_ign = 0, m_sd = 0;
    longint m_phase = 0, m_per = 0, m_k = 0, m_since = 0;

    function automatic logic [N_CYL-1:0] cyl_of(input longint k);
        logic [N_CYL-1:0] v;
        v = '0;
        v[int'(k % N_CYL)] = 1'b1;
        return v;
    endfunction

    task automatic ramp_update();
        longint pe, st, d;
        pe = period_end;
        st = period_step;
        d  = (m_per > pe) ? m_per - pe : pe - m_per;
        if (d <= st) begin
            m_per  = (pe < 2) ? 2 : pe;
            m_hold = 1;
            m_sd   = 1;
        end else if (m_per > pe) begin
            m_per = m_per - st;
            if (m_per < 2) m_per = 2;
        end else begin
            m_per = m_per + st;
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        if (rst) begin
            m_run = 0; m_hold = 0; m_phase = 0; m_per = 0; m_k = 0;
            m_since = 0; m_trig = 0; m_ign = 0; m_sd = 0;
        end else if (!m_run) begin
            m_trig = 0; m_ign = 0; m_phase = 0; m_k = 0; m_sd = 0; m_hold = 0;
            if (en) begin
                m_run   = 1;
                m_per   = (period_start < 2) ? 2 : longint'(period_start);
                m_since = 0;
`ifdef STIM_RAMP_EN
                if (period_start == period_end) begin
                    m_hold = 1;
                    m_sd   = 1;
                end
`endif
            end
        end else if (!en) begin
            m_run = 0; m_hold = 0; m_trig = 0; m_ign = 0;
            m_phase = 0; m_k = 0; m_sd = 0;
        end else begin
            m_trig = (m_phase >= longint'(trig_pos)) &&
                     (m_phase < longint'(trig_pos) + longint'(trig_len));
            m_ign  = (m_phase >= longint'(ign_pos));
            if (m_phase == m_per - 1) begin
                m_phase = 0;
                m_k++;
`ifdef STIM_RAMP_EN
                if (!m_hold) begin
                    if (m_since >= longint'(ramp_div)) begin
                        m_since = 0;
                        ramp_update();
                    end else begin
                        m_since++;
                    end
                end
`endif
            end else begin
                m_phase++;
            end
        end
        e.trig = m_trig;
        e.ign  = m_ign;
        e.cyl  = cyl_of(m_k);
        e.pc   = m_per[CNT_W-1:0];
        e.sd   = m_sd;
        exp_q.push_back(e);
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("trigger", trigger, e.trig);
            check("ign", ign, e.ign);
            check("cyl", cyl, e.cyl);
            check("period_cur", period_cur, e.pc);
            check("sweep_done", sweep_done, e.sd);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic stop_run();
        en = 1'b0;
        cycles(3);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int ign_cnt, trig_cnt, waited;

        cycles(3);
        check("reset_period_cur", period_cur, 0);
        check("reset_cyl", cyl, 4'b0001);
        check("reset_outputs", {trigger, ign, sweep_done}, 3'b000);
        rst = 1'b0;
        cycles(2);

        // Fixed 10-clock period: one trigger clock and two ignition clocks.
        period_start = 10; period_end = 10; period_step = 0; ramp_div = 0;
        trig_pos = 2; trig_len = 1; ign_pos = 8;
        en = 1'b1;
        cycles(15);
        ign_cnt = 0; trig_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            ign_cnt  += int'(ign);
            trig_cnt += int'(trigger);
        end
        check("ign_clocks_per_period", ign_cnt, 2);
        check("trigger_clocks_per_period", trig_cnt, 1);
        cycles(30);
        stop_run();

`ifdef STIM_RAMP_EN
        // Downward sweep 100 -> 70 in steps of 10, two periods per step.
        period_start = 100; period_end = 70; period_step = 10; ramp_div = 1;
        en = 1'b1;
        waited = 0;
        while (!sweep_done && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        check("sweep_down_reached", (waited < 2000), 1);
        check("sweep_down_period", period_cur, 70);
        cycles(150);
        stop_run();

        // Upward sweep with step larger than the distance: single update.
        period_start = 70; period_end = 100; period_step = 40; ramp_div = 0;
        en = 1'b1;
        waited = 0;
        while (!sweep_done && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        check("sweep_up_reached", (waited < 500), 1);
        check("sweep_up_period", period_cur, 100);
        stop_run();
`else
        // Without the ramp the period never moves toward period_end.
        period_start = 50; period_end = 20; period_step = 5; ramp_div = 0;
        en = 1'b1;
        cycles(400);
        check("fixed_period", period_cur, 50);
        check("fixed_sweep_done", sweep_done, 0);
        stop_run();
`endif

        // Asynchronous reset in the middle of a period, enable kept high.
        period_start = 20; period_end = 60; period_step = 3; ramp_div = 0;
        trig_pos = 1; trig_len = 4; ign_pos = 2;
        en = 1'b1;
        repeat (6) @(posedge clk);
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("async_rst_period_cur", period_cur, 0);
        check("async_rst_cyl", cyl, 4'b0001);
        check("async_rst_outputs", {trigger, ign, sweep_done}, 3'b000);
        cycles(2);
        rst = 1'b0;
        cycles(60);
        stop_run();

        // Randomized runs, including mid-run input changes.
        for (int r = 0; r < 25; r++) begin
            period_start = CNT_W'($urandom_range(0, 40));
            period_end   = CNT_W'($urandom_range(2, 40));
            period_step  = STEP_W'($urandom_range(0, 12));
            ramp_div     = 8'($urandom_range(0, 3));
            trig_pos     = CNT_W'($urandom_range(0, 45));
            trig_len     = CNT_W'($urandom_range(0, 8));
            ign_pos      = CNT_W'($urandom_range(0, 45));
            if ($urandom_range(0, 4) == 0) trig_len = {CNT_W{1'b1}};
            en = 1'b1;
            cycles($urandom_range(20, 120));
            trig_pos     = CNT_W'($urandom_range(0, 45));
            ign_pos      = CNT_W'($urandom_range(0, 45));
            period_start = CNT_W'($urandom_range(0, 40));
            cycles($urandom_range(10, 80));
            en = 1'b0;
            cycles($urandom_range(1, 3));
        end
        cycles(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
